shake_arbiter: RTL and testbench

Round-robin arbiter that shares a single SHAKE wrapper instance between `N_REQ` independent requesters. It latches the winner's job configuration (mode, block count, last-block byte count), issues the one-cycle `init` to the core, and steers seed data in and squeeze output back. It holds the grant until the owning requester releases it. It sits directly above the SHAKE wrapper and is the only block that drives the wrapper's control inputs.

---
 rtl/shake_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_shake_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shake_arbiter.sv
// ---------------------------------------------------------------------------
// shake_arbiter
//
// Round-robin arbiter sharing one SHAKE wrapper between N_REQ requesters.
// The winner's job configuration (mode, absorb block count, last-block byte
// count) is latched when it is granted. The arbiter then issues a one-cycle
// core_init and steers the winner's seed word to the core. The core's
// squeeze output is broadcast to everyone, with valid qualified per grant.
// The grant is held until the owner pulses its release_req bit.
//
// Optional feature macro: SHAKE_ARB_TIMEOUT_EN
//   When defined, a watchdog forces a release after TIMEOUT_CYCLES BUSY
//   cycles and pulses timeout_err. When undefined, timeout_err is tied to 0.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req                  per-requester job request (level)
//   release_req          per-requester end-of-job pulse
//   mode_req             per-requester mode (0 SHAKE128, 1 SHAKE256)
//   absorb_num_req       per-requester absorb block count, 8 bits each, packed
//   last_bytes_req       per-requester last-block byte count, 6 bits each
//   seed_buf_req         per-requester seed word, 32 bits each, packed
//   gnt / gnt_id / busy  one-hot grant, owner index, core-owned flag
//   addr_seed, dout      core seed address and squeeze word, broadcast
//   dout_valid           core valid qualified by gnt
//   timeout_err          one-cycle watchdog pulse
//   core_*               wrapper control/data inputs and outputs
// ---------------------------------------------------------------------------
module shake_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req,
    input  logic [N_REQ-1:0]               release_req,
    input  logic [N_REQ-1:0]               mode_req,
    input  logic [N_REQ*8-1:0]             absorb_num_req,
    input  logic [N_REQ*6-1:0]             last_bytes_req,
    input  logic [N_REQ*32-1:0]            seed_buf_req,
    output logic [N_REQ-1:0]               gnt,
    output logic [$clog2(N_REQ)-1:0]       gnt_id,
    output logic                           busy,
    output logic [31:0]                    addr_seed,
    output logic [31:0]                    dout,
    output logic [N_REQ-1:0]               dout_valid,
    output logic                           timeout_err,
    output logic                           core_init,
    output logic                           core_mode,
    output logic [7:0]                     core_absorb_num,
    output logic [5:0]                     core_last_bytes,
    output logic [31:0]                    core_seed_buffer,
    input  logic [31:0]                    core_addr_seed,
    input  logic [31:0]                    core_dout,
    input  logic                           core_valid,
    input  logic                           core_ready
);

    localparam int IDW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [IDW-1:0]         r_rr_ptr;
    logic [N_REQ-1:0]       r_gnt;
    logic [IDW-1:0]         r_gnt_id;
    logic                   r_busy;
    logic                   r_core_init;
    logic                   r_core_mode;
    logic [7:0]             r_core_absorb_num;
    logic [5:0]             r_core_last_bytes;

    logic                   w_any;
    logic [IDW-1:0]         w_sel;
    logic                   w_release;
    logic [IDW-1:0]         w_next_ptr;
    logic                   w_unused;

    // core_ready is reported by the wrapper but never used for sequencing.
    assign w_unused = core_ready | (TIMEOUT_CYCLES < 0);

    // Cyclic search: walk downward from the farthest offset so that the last
    // hit written is the one closest to (at or after) the pointer.
    always_comb begin
        int idx;
        w_any = 1'b0;
        w_sel = '0;
        idx   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req[idx]) begin
                w_any = 1'b1;
                w_sel = IDW'(idx);
            end
        end
    end

    assign w_release  = release_req[r_gnt_id];
    assign w_next_ptr = (r_gnt_id == IDW'(N_REQ - 1)) ? '0 : r_gnt_id + 1'b1;

`ifdef SHAKE_ARB_TIMEOUT_EN
    logic [31:0] r_wd_cnt;
    logic        r_timeout_err;
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_rr_ptr          <= '0;
            r_gnt             <= '0;
            r_gnt_id          <= '0;
            r_busy            <= 1'b0;
            r_core_init       <= 1'b0;
            r_core_mode       <= 1'b0;
            r_core_absorb_num <= '0;
            r_core_last_bytes <= '0;
`ifdef SHAKE_ARB_TIMEOUT_EN
            r_wd_cnt          <= '0;
            r_timeout_err     <= 1'b0;
`endif
        end else begin
            r_core_init <= 1'b0;
`ifdef SHAKE_ARB_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state           <= S_START;
                        r_gnt             <= N_REQ'(1) << w_sel;
                        r_gnt_id          <= w_sel;
                        r_busy            <= 1'b1;
                        r_core_init       <= 1'b1;
                        r_core_mode       <= mode_req[w_sel];
                        r_core_absorb_num <= absorb_num_req[int'(w_sel)*8 +: 8];
                        r_core_last_bytes <= last_bytes_req[int'(w_sel)*6 +: 6];
                    end
                end
                S_START: begin
                    // Release is deliberately not looked at here.
                    r_state <= S_BUSY;
`ifdef SHAKE_ARB_TIMEOUT_EN
                    r_wd_cnt <= '0;
`endif
                end
                S_BUSY: begin
                    if (w_release) begin
                        r_state  <= S_IDLE;
                        r_gnt    <= '0;
                        r_busy   <= 1'b0;
                        r_rr_ptr <= w_next_ptr;
`ifdef SHAKE_ARB_TIMEOUT_EN
                    end else if (r_wd_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        // Forced release; a genuine release above wins.
                        r_state       <= S_IDLE;
                        r_gnt         <= '0;
                        r_busy        <= 1'b0;
                        r_rr_ptr      <= w_next_ptr;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 32'd1;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt             = r_gnt;
    assign gnt_id          = r_gnt_id;
    assign busy            = r_busy;
    assign core_init       = r_core_init;
    assign core_mode       = r_core_mode;
    assign core_absorb_num = r_core_absorb_num;
    assign core_last_bytes = r_core_last_bytes;

    // Data steering between the core and the current owner.
    assign core_seed_buffer = r_busy ? seed_buf_req[int'(r_gnt_id)*32 +: 32] : 32'd0;
    assign addr_seed        = core_addr_seed;
    assign dout             = core_dout;
    assign dout_valid       = {N_REQ{core_valid}} & r_gnt;

endmodule

// File: tb/tb_shake_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shake_arbiter
//
// Directed bench for shake_arbiter (N_REQ = 4, TIMEOUT_CYCLES = 16).
// Inputs are driven 1 time unit after each rising edge, and outputs are
// checked at that same point, i.e. away from the active edge.
// ---------------------------------------------------------------------------
module tb_shake_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [3:0]   release_req;
    logic [3:0]   mode_req;
    logic [31:0]  absorb_num_req;
    logic [23:0]  last_bytes_req;
    logic [127:0] seed_buf_req;
    logic [3:0]   gnt;
    logic [1:0]   gnt_id;
    logic         busy;
    logic [31:0]  addr_seed;
    logic [31:0]  dout;
    logic [3:0]   dout_valid;
    logic         timeout_err;
    logic         core_init;
    logic         core_mode;
    logic [7:0]   core_absorb_num;
    logic [5:0]   core_last_bytes;
    logic [31:0]  core_seed_buffer;
    logic [31:0]  core_addr_seed;
    logic [31:0]  core_dout;
    logic         core_valid;
    logic         core_ready;

    int n_assert;
    int n_fail;

    shake_arbiter #(
        .N_REQ          (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req              (req),
        .release_req      (release_req),
        .mode_req         (mode_req),
        .absorb_num_req   (absorb_num_req),
        .last_bytes_req   (last_bytes_req),
        .seed_buf_req     (seed_buf_req),
        .gnt              (gnt),
        .gnt_id           (gnt_id),
        .busy             (busy),
        .addr_seed        (addr_seed),
        .dout             (dout),
        .dout_valid       (dout_valid),
        .timeout_err      (timeout_err),
        .core_init        (core_init),
        .core_mode        (core_mode),
        .core_absorb_num  (core_absorb_num),
        .core_last_bytes  (core_last_bytes),
        .core_seed_buffer (core_seed_buffer),
        .core_addr_seed   (core_addr_seed),
        .core_dout        (core_dout),
        .core_valid       (core_valid),
        .core_ready       (core_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " gnt"},         64'(gnt),              64'h0);
        chk({tag, " gnt_id"},      64'(gnt_id),           64'h0);
        chk({tag, " busy"},        64'(busy),             64'h0);
        chk({tag, " core_init"},   64'(core_init),        64'h0);
        chk({tag, " core_mode"},   64'(core_mode),        64'h0);
        chk({tag, " absorb"},      64'(core_absorb_num),  64'h0);
        chk({tag, " last_bytes"},  64'(core_last_bytes),  64'h0);
        chk({tag, " timeout_err"}, 64'(timeout_err),      64'h0);
        chk({tag, " seed_buf"},    64'(core_seed_buffer), 64'h0);
        chk({tag, " dout_valid"},  64'(dout_valid),       64'h0);
    endtask

    task automatic release_owner(input int id);
        release_req     = '0;
        release_req[id] = 1'b1;
        tick();
        release_req = '0;
    endtask

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};
        n_assert = 0;
        n_fail   = 0;

        rst            = 1'b1;
        req            = '0;
        release_req    = '0;
        mode_req       = '0;
        absorb_num_req = '0;
        last_bytes_req = '0;
        seed_buf_req   = {4{32'hDEAD_BEEF}};
        core_addr_seed = '0;
        core_dout      = '0;
        core_valid     = 1'b1;   // must be masked while nobody owns the core
        core_ready     = 1'b1;
        tick();
        tick();
        chk_reset_state("reset");
        core_valid = 1'b0;
        rst        = 1'b0;
        tick();

        // ---- single grant and configuration latch ----
        req                    = 4'b0100;
        mode_req[2]            = 1'b1;
        absorb_num_req[23:16]  = 8'd3;
        last_bytes_req[17:12]  = 6'd17;
        tick();
        chk("t1 gnt",       64'(gnt),             64'h4);
        chk("t1 gnt_id",    64'(gnt_id),          64'h2);
        chk("t1 busy",      64'(busy),            64'h1);
        chk("t1 init",      64'(core_init),       64'h1);
        chk("t1 mode",      64'(core_mode),       64'h1);
        chk("t1 absorb",    64'(core_absorb_num), 64'd3);
        chk("t1 last",      64'(core_last_bytes), 64'd17);
        mode_req[2]            = 1'b0;
        absorb_num_req[23:16]  = 8'd99;
        last_bytes_req[17:12]  = 6'd5;
        tick();
        chk("t1 init low",  64'(core_init),       64'h0);
        chk("t1 mode held", 64'(core_mode),       64'h1);
        tick();
        chk("t1 init low2", 64'(core_init),       64'h0);
        chk("t1 abs held",  64'(core_absorb_num), 64'd3);
        chk("t1 last held", 64'(core_last_bytes), 64'd17);
        release_owner(2);
        chk("t1 rel gnt",   64'(gnt),             64'h0);
        chk("t1 rel busy",  64'(busy),            64'h0);
        req = '0;
        tick();

        // ---- round robin from a fresh pointer ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rr%0d gnt", k),    64'(gnt),    64'(4'b0001 << order[k]));
            chk($sformatf("rr%0d gnt_id", k), 64'(gnt_id), 64'(order[k]));
            repeat (4) tick();
            release_owner(order[k]);
            chk($sformatf("rr%0d idle gnt", k),  64'(gnt),  64'h0);
            chk($sformatf("rr%0d idle busy", k), 64'(busy), 64'h0);
        end
        req = '0;
        tick();

        // ---- steering: pointer now 1, requester 1 owns the core ----
        seed_buf_req[63:32] = 32'hA5A5_0001;
        req = 4'b0010;
        tick();
        chk("st gnt",  64'(gnt),              64'h2);
        chk("st seed", 64'(core_seed_buffer), 64'hA5A5_0001);
        tick();
        core_valid     = 1'b1;
        core_dout      = 32'h1234_5678;
        core_addr_seed = 32'h0000_0040;
        #1;
        chk("st dvalid", 64'(dout_valid), 64'h2);
        chk("st dout",   64'(dout),       64'h1234_5678);
        chk("st addr",   64'(addr_seed),  64'h40);
        core_valid = 1'b0;
        release_owner(1);
        req = '0;
        tick();

        // ---- foreign release and release during START (pointer 2) ----
        req = 4'b0001;
        tick();
        chk("fr gnt start", 64'(gnt), 64'h1);
        release_req = 4'b0001;      // owner's release seen only in START
        tick();
        release_req = 4'b0000;
        chk("fr start rel", 64'(gnt), 64'h1);
        release_req = 4'b1000;
        tick();
        release_req = 4'b0000;
        tick();
        chk("fr foreign gnt",  64'(gnt),  64'h1);
        chk("fr foreign busy", 64'(busy), 64'h1);
        release_owner(0);
        req = '0;
        tick();

        // ---- reset mid-job with owner 2 (pointer 1) ----
        req = 4'b0100;
        tick();
        tick();
        chk("mr gnt", 64'(gnt), 64'h4);
        req = 4'b0110;
        rst = 1'b1;
        tick();
        chk_reset_state("midrst");
        rst = 1'b0;
        tick();
        chk("mr regnt",    64'(gnt),    64'h2);
        chk("mr regnt id", 64'(gnt_id), 64'h1);

        // ---- owner 1 never releases ----
`ifdef SHAKE_ARB_TIMEOUT_EN
        repeat (16) tick();
        chk("wd held",   64'(gnt),         64'h2);
        chk("wd no err", 64'(timeout_err), 64'h0);
        tick();
        chk("wd err",    64'(timeout_err), 64'h1);
        chk("wd drop",   64'(gnt),         64'h0);
        tick();
        chk("wd err end", 64'(timeout_err), 64'h0);
        chk("wd next",    64'(gnt),         64'h4);
        req = '0;
        tick();
        release_owner(2);
`else
        repeat (1000) tick();
        chk("wd held",   64'(gnt),         64'h2);
        chk("wd busy",   64'(busy),        64'h1);
        chk("wd no err", 64'(timeout_err), 64'h0);
        release_owner(1);
`endif
        req = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
